// File: rtl/etc_pkg.sv
// Semiring op codes and element-level combine/reduce helpers shared by the MMA datapath.
// Helpers work on a wide element; callers truncate to their own width (add/mul wrap naturally).
package etc_pkg;

  localparam int XW = 64;

  typedef logic [XW-1:0] elem_t;

  typedef enum logic [2:0] {
    OP_PLUS_MUL = 3'd0,
    OP_MIN_PLUS = 3'd1,
    OP_MAX_PLUS = 3'd2,
    OP_MAX_MIN  = 3'd3,
    OP_MIN_MAX  = 3'd4,
    OP_OR_AND   = 3'd5
  } op_e;

  // Codes at or above this value are reserved.
  localparam logic [2:0] OP_RSVD = 3'd6;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op >= OP_RSVD;
  endfunction

  function automatic elem_t etc_min(input elem_t a, input elem_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic elem_t etc_max(input elem_t a, input elem_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic elem_t etc_combine(input logic [2:0] op, input elem_t a, input elem_t b);
    case (op)
      OP_PLUS_MUL: return a * b;
      OP_MIN_PLUS: return a + b;
      OP_MAX_PLUS: return a + b;
      OP_MAX_MIN:  return etc_min(a, b);
      OP_MIN_MAX:  return etc_max(a, b);
      OP_OR_AND:   return a & b;
      default:     return '0;
    endcase
  endfunction

  function automatic elem_t etc_reduce(input logic [2:0] op, input elem_t a, input elem_t b);
    case (op)
      OP_PLUS_MUL: return a + b;
      OP_MIN_PLUS: return etc_min(a, b);
      OP_MAX_PLUS: return etc_max(a, b);
      OP_MAX_MIN:  return etc_max(a, b);
      OP_MIN_MAX:  return etc_min(a, b);
      OP_OR_AND:   return a | b;
      default:     return '0;
    endcase
  endfunction

  // Identity of the reduce operator, used to pad the tree up to a power of two.
  function automatic elem_t etc_ident(input logic [2:0] op);
    case (op)
      OP_MIN_PLUS, OP_MIN_MAX: return '1;
      default:                 return '0;
    endcase
  endfunction

endpackage

// File: rtl/etc_semiring_dot.sv
// Combinational length-N dot product over a runtime-selected semiring.
// Reduction is a balanced tree padded with the reduce identity; reserved ops yield 0.
module etc_semiring_dot
  import etc_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic [2:0]     op,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic [W-1:0]   r
);

  localparam int P = (N <= 1) ? 1 : (1 << $clog2(N));

  logic [W-1:0] node [1:2*P-1];

  generate
    for (genvar k = 0; k < P; k++) begin : gLeaf
      if (k < N) begin : gReal
        assign node[P+k] = W'(etc_combine(op, XW'(a[k*W +: W]), XW'(b[k*W +: W])));
      end else begin : gPad
        assign node[P+k] = W'(etc_ident(op));
      end
    end
    for (genvar n = P - 1; n >= 1; n--) begin : gTree
      assign node[n] = W'(etc_reduce(op, XW'(node[2*n]), XW'(node[2*n+1])));
    end
  endgenerate

  assign r = node[1];

endmodule

// File: rtl/etc_semiring_mma.sv
// NxN semiring tile MMA accumulating across K-tiles: S1 input register, S2 accumulator/output.
// Single-tile result two edges after the beat is offered; out stall freezes S1 and drops in_ready.
module etc_semiring_mma
  import etc_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [N*N*W-1:0]   in_a,
  input  logic [N*N*W-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*N*W-1:0]   out_d,
  output logic [CNT_W-1:0]   out_tiles,
  output logic               out_err
);

  localparam int TW = N * N * W;

  logic             s1Valid;
  logic             s1First;
  logic             s1Last;
  logic [2:0]       s1Op;
  logic [TW-1:0]    s1A;
  logic [TW-1:0]    s1B;

  logic             accOpen;
  logic [2:0]       opQ;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0]    acc;

  logic             stall;
  logic             s1Adv;
  logic             inFire;
  logic             startNew;
  logic [2:0]       effOp;
  logic [TW-1:0]    prod;
  logic [TW-1:0]    accNext;
  logic [CNT_W-1:0] cntNext;

  assign stall    = out_valid && !out_ready;
  assign s1Adv    = s1Valid && !stall;
  assign in_ready = rst_n && !stall && (!s1Valid || s1Adv);
  assign inFire   = in_valid && in_ready;

  // A continuation beat with no open sequence restarts it under the held op.
  assign startNew = s1First || !accOpen;
  assign effOp    = s1First ? s1Op : opQ;

  generate
    for (genvar i = 0; i < N; i++) begin : gRow
      for (genvar j = 0; j < N; j++) begin : gCol
        logic [N*W-1:0] colB;
        for (genvar k = 0; k < N; k++) begin : gGather
          assign colB[k*W +: W] = s1B[(k*N+j)*W +: W];
        end
        etc_semiring_dot #(.N(N), .W(W)) uDot (
          .op (effOp),
          .a  (s1A[i*N*W +: N*W]),
          .b  (colB),
          .r  (prod[(i*N+j)*W +: W])
        );
      end
    end
  endgenerate

  always_comb begin
    accNext = '0;
    for (int e = 0; e < N * N; e++) begin
      accNext[e*W +: W] = startNew ? prod[e*W +: W]
                                   : W'(etc_reduce(effOp, XW'(acc[e*W +: W]), XW'(prod[e*W +: W])));
    end
    cntNext = startNew ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1First <= 1'b0;
      s1Last  <= 1'b0;
      s1Op    <= '0;
      s1A     <= '0;
      s1B     <= '0;
    end else if (inFire) begin
      s1Valid <= 1'b1;
      s1First <= in_first;
      s1Last  <= in_last;
      s1Op    <= in_op;
      s1A     <= in_a;
      s1B     <= in_b;
    end else if (s1Adv) begin
      s1Valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accOpen   <= 1'b0;
      opQ       <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_d     <= '0;
      out_tiles <= '0;
      out_err   <= 1'b0;
    end else begin
      if (s1Adv) begin
        acc     <= accNext;
        cnt     <= cntNext;
        opQ     <= effOp;
        accOpen <= !s1Last;
      end
      // A new result loading in the same cycle as an output fire keeps out_valid high.
      if (s1Adv && s1Last) begin
        out_valid <= 1'b1;
        out_d     <= accNext;
        out_tiles <= cntNext;
        out_err   <= op_is_reserved(effOp);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_etc_semiring_mma.sv
// Directed-vector bench for etc_semiring_mma with a queue scoreboard and a decoupled output monitor.
module tb_etc_semiring_mma;

  typedef logic [255:0] tile_t;
  typedef struct {
    tile_t      d;
    logic [7:0] tiles;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_first;
  logic        in_last;
  tile_t       in_a;
  tile_t       in_b;
  logic        out_valid;
  logic        out_ready;
  tile_t       out_d;
  logic [7:0]  out_tiles;
  logic        out_err;

  exp_t sbQ[$];
  int   nCmp = 0;
  int   nErr = 0;

  etc_semiring_mma #(.N(4), .W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_tiles (out_tiles),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  function automatic tile_t put(input tile_t t, input int r, input int c, input int v);
    t[(r*4+c)*16 +: 16] = 16'(v);
    return t;
  endfunction

  function automatic tile_t fill(input int v);
    tile_t t = '0;
    for (int e = 0; e < 16; e++) t[e*16 +: 16] = 16'(v);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pushExp(input tile_t d, input int tiles, input logic err);
    exp_t e;
    e.d = d;
    e.tiles = 8'(tiles);
    e.err = err;
    sbQ.push_back(e);
  endtask

  // Offer one beat; returns just after the accepting edge with in_valid still asserted.
  task automatic beat(input logic [2:0] op, input logic f, input logic l,
                      input tile_t a, input tile_t b, output int waits);
    in_valid = 1'b1; in_op = op; in_first = f; in_last = l; in_a = a; in_b = b;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      nCmp++; nErr++;
      $display("FAIL beat_timeout: in_ready stuck low, wanted 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w = 0;
    while (sbQ.size() != 0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    chk(nm, 256'(sbQ.size()), 256'(0));
    @(posedge clk); #1;
  endtask

  // Output monitor: every presented result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      nCmp++;
      if (sbQ.size() == 0) begin
        nErr++;
        $display("FAIL out_unexpected: got d=%0h tiles=%0d, wanted no result", out_d, out_tiles);
      end else begin
        if ({out_d, out_tiles, out_err} !== {sbQ[0].d, sbQ[0].tiles, sbQ[0].err}) begin
          nErr++;
          $display("FAIL out_tile: got d=%0h tiles=%0d err=%0b want d=%0h tiles=%0d err=%0b",
                   out_d, out_tiles, out_err, sbQ[0].d, sbQ[0].tiles, sbQ[0].err);
        end
        if (out_ready) void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tile_t ident, bPat, aK, bK, bOr, aRow, bCol, bMm, expRow;
    int w;
    ident = '0; bPat = '0; aK = '0; bK = '0; bOr = '0; aRow = '0; bCol = '0; bMm = '0; expRow = '0;
    for (int i = 0; i < 4; i++) begin
      ident = put(ident, i, i, 1);
      for (int j = 0; j < 4; j++) begin
        bPat   = put(bPat, i, j, 4*i + j);
        bK     = put(bK, i, j, i + 1);
        aK     = put(aK, i, j, j);
        bOr    = put(bOr, i, j, 16'h0011 << i);
        aRow   = put(aRow, i, j, i);
        bCol   = put(bCol, i, j, i);
        bMm    = put(bMm, i, j, 3*i);
        expRow = put(expRow, i, j, i + 3);
      end
    end

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_first = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_tiles", 256'(out_tiles), 256'(0));
    chk("rst_out_d", out_d, 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Identity times B under plus/mul, plus latency check.
    pushExp(bPat, 1, 1'b0);
    beat(3'd0, 1'b1, 1'b1, ident, bPat, w);
    idle();
    @(negedge clk);
    chk("lat_edge1", 256'(out_valid), 256'(0));
    @(negedge clk);
    chk("lat_edge2", 256'(out_valid), 256'(1));
    @(posedge clk); #1;

    // min/plus
    pushExp(fill(4), 1, 1'b0);
    beat(3'd1, 1'b1, 1'b1, fill(3), bK, w);
    idle();
    drain("drain_minplus");

    // Three back-to-back tiles accumulated under plus/mul.
    pushExp(fill(24), 3, 1'b0);
    beat(3'd0, 1'b1, 1'b0, fill(1), fill(2), w);
    chk("b2b_rdy0", 256'(w), 256'(0));
    beat(3'd0, 1'b0, 1'b0, fill(1), fill(2), w);
    chk("b2b_rdy1", 256'(w), 256'(0));
    beat(3'd0, 1'b0, 1'b1, fill(1), fill(2), w);
    chk("b2b_rdy2", 256'(w), 256'(0));
    idle();
    drain("drain_b2b");

    // max/min held under backpressure, followed by a wrapping plus/mul tile.
    out_ready = 1'b0;
    pushExp(fill(3), 1, 1'b0);
    beat(3'd3, 1'b1, 1'b1, aK, fill(16'hFFFF), w);
    pushExp(fill(0), 1, 1'b0);
    beat(3'd0, 1'b1, 1'b1, fill(16'h0100), fill(16'h0100), w);
    idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 256'(in_ready), 256'(0));
      chk("stall_out_valid", 256'(out_valid), 256'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("drain_stall");

    // Reserved op.
    pushExp(fill(0), 1, 1'b1);
    beat(3'd7, 1'b1, 1'b1, fill(5), fill(7), w);
    idle();
    drain("drain_rsvd");

    // in_op ignored on a continuation beat.
    pushExp(fill(16), 2, 1'b0);
    beat(3'd0, 1'b1, 1'b0, fill(1), fill(2), w);
    beat(3'd1, 1'b0, 1'b1, fill(1), fill(2), w);
    idle();
    drain("drain_opignore");

    // max/plus, min/max and or/and.
    pushExp(expRow, 1, 1'b0);
    beat(3'd2, 1'b1, 1'b1, aRow, bCol, w);
    pushExp(fill(5), 1, 1'b0);
    beat(3'd4, 1'b1, 1'b1, fill(5), bMm, w);
    pushExp(fill(16'h00F0), 1, 1'b0);
    beat(3'd5, 1'b1, 1'b1, fill(16'h00F0), bOr, w);
    idle();
    drain("drain_ops");

    // Reset between the first and last beats of a 3-tile sequence.
    beat(3'd0, 1'b1, 1'b0, fill(1), fill(2), w);
    beat(3'd0, 1'b0, 1'b0, fill(1), fill(2), w);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_out", 256'(out_valid), 256'(0));
    end
    @(posedge clk); #1;
    pushExp(bPat, 1, 1'b0);
    beat(3'd0, 1'b1, 1'b1, ident, bPat, w);
    idle();
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
    $finish;
  end

endmodule
